// File: rtl/calc_sequencer_pkg.sv
// Shared definitions for the calculator sequencer: opcodes, FSM states,
// instruction field positions and the decoded-control bundle.
package calc_sequencer_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUBI = 4'h2;
  localparam logic [3:0] OP_ADDP = 4'h3;
  localparam logic [3:0] OP_SUBP = 4'h4;
  localparam logic [3:0] OP_CLR  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 28;
  localparam int IMMA_MSB = 27;
  localparam int IMMA_LSB = 14;
  localparam int IMMB_MSB = 13;
  localparam int IMMB_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  // arith marks the ops whose adder overflow can trap; clr_imm forces both immediates to zero
  typedef struct packed {
    logic sign;
    logic store_prev;
    logic acc_we;
    logic is_halt;
    logic illegal;
    logic arith;
    logic clr_imm;
  } dec_t;

endpackage

// File: rtl/calc_decode.sv
// Combinational opcode decoder: maps a 4-bit opcode to the datapath control bundle.
module calc_decode
  import calc_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_NOP: ;
      OP_ADDI: begin
        dec.store_prev = 1'b1;
        dec.acc_we     = 1'b1;
        dec.arith      = 1'b1;
      end
      OP_SUBI: begin
        dec.sign       = 1'b1;
        dec.store_prev = 1'b1;
        dec.acc_we     = 1'b1;
        dec.arith      = 1'b1;
      end
      OP_ADDP: begin
        dec.acc_we = 1'b1;
        dec.arith  = 1'b1;
      end
      OP_SUBP: begin
        dec.sign   = 1'b1;
        dec.acc_we = 1'b1;
        dec.arith  = 1'b1;
      end
      // CLR is ADDI of two zero immediates, so it never overflows
      OP_CLR: begin
        dec.store_prev = 1'b1;
        dec.acc_we     = 1'b1;
        dec.clr_imm    = 1'b1;
      end
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/calc_sequencer.sv
// Multi-cycle controller for the calculator datapath (fetch/decode/execute/writeback).
// Optional overflow trap enabled by defining CALC_OVF_TRAP_EN.
module calc_sequencer
  import calc_sequencer_pkg::*;
#(
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_instr,
  output logic        pc_wr_en,
  output logic        acc_wr_en,
  output logic        sign_ctrl,
  output logic        store_prev_ctrl,
  output logic [13:0] imm_a,
  output logic [13:0] imm_b,
  input  logic        addsub_ovf,
  output logic        busy,
  output logic        halted,
  output logic        fault
);

  localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  // The PC register and adder sit outside; instruction addresses must stay word aligned.
  if (PC_STEP == 32'd0 || PC_STEP[1:0] != 2'b00 || RESET_PC[1:0] != 2'b00 || MAX_WAIT < 1)
  begin : g_bad_params
    $error("calc_sequencer: PC_STEP/RESET_PC must be word aligned and MAX_WAIT >= 1");
  end

  state_e            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q, fault_d;
  dec_t              dec;

  calc_decode u_decode (
    .opcode (instr_q[OPC_MSB:OPC_LSB]),
    .dec    (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          wait_d  = '0;
        end
      end
      ST_FETCH: begin
        // A ready that shows up only once the limit is reached still counts as a timeout
        if (wait_q == WAIT_LIMIT) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
          wait_d  = '0;
        end else if (imem_ready) begin
          instr_d = imem_instr;
          state_d = ST_DECODE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DECODE: begin
        if (dec.illegal) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else if (dec.is_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
`ifdef CALC_OVF_TRAP_EN
        if (dec.arith && addsub_ovf) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_WRITEBACK;
        end
`else
        state_d = ST_WRITEBACK;
`endif
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_HALT: begin
        if (start && !fault_q) begin
          state_d = ST_FETCH;
          wait_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifndef CALC_OVF_TRAP_EN
  logic unused_ovf;
  assign unused_ovf = addsub_ovf ^ dec.arith;
`endif

  // Controls come straight off the state and instruction flops, so reset clears them at once
  assign imem_req        = (state_q == ST_FETCH);
  assign pc_wr_en        = (state_q == ST_WRITEBACK);
  assign acc_wr_en       = (state_q == ST_WRITEBACK) && dec.acc_we;
  assign sign_ctrl       = dec.sign;
  assign store_prev_ctrl = dec.store_prev;
  assign imm_a           = dec.clr_imm ? 14'd0 : instr_q[IMMA_MSB:IMMA_LSB];
  assign imm_b           = dec.clr_imm ? 14'd0 : instr_q[IMMB_MSB:IMMB_LSB];
  assign busy            = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                           (state_q == ST_EXECUTE) || (state_q == ST_WRITEBACK);
  assign halted          = (state_q == ST_HALT);
  assign fault           = fault_q;

endmodule
